// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
//   rf_wr_t          : one queued write {register address, data}
//   RF_WR_W          : flat width of rf_wr_t for module ports
//   R15_ADDR         : address of the externally supplied (non-stored) register
//   NUM_STORED_REGS  : registers R0-R14 held in the file
//   grant_e          : owner of the write port for the current edge
//   reg_onehot()     : one-hot decode of a stored-register address (R15 decodes to zero)
package rf_arb_pkg;

    typedef struct packed {
        logic [3:0]  wa;
        logic [31:0] wd;
    } rf_wr_t;

    localparam int unsigned RF_WR_W         = $bits(rf_wr_t);
    localparam logic [3:0]  R15_ADDR        = 4'hF;
    localparam int unsigned NUM_STORED_REGS = 15;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_AUX  = 2'd2
    } grant_e;

    function automatic logic [NUM_STORED_REGS-1:0] reg_onehot(input logic [3:0] wa);
        logic [NUM_STORED_REGS-1:0] oh;
        oh = '0;
        for (int unsigned j = 0; j < NUM_STORED_REGS; j++) begin
            if (wa == 4'(j)) oh[j] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// DEPTH-entry FIFO of register-file writes feeding the arbiter's aux path.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data : write push_data at the edge (caller guarantees !full)
//   pop          : drop the head entry at the edge (caller guarantees !empty)
//   head         : current head entry (valid when !empty)
//   full, empty, count : occupancy status from registered state
//   entry_valid, entry_wa : per-slot valid flag and address, for the busy mask
module rf_wr_fifo
    import rf_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [RF_WR_W-1:0]      push_data,
    input  logic                    pop,
    output logic [RF_WR_W-1:0]      head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic [DEPTH-1:0]        entry_valid,
    output logic [4*DEPTH-1:0]      entry_wa
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    rf_wr_t             mem_q [DEPTH];
    rf_wr_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = rf_wr_t'(push_data);
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        logic [PTR_W-1:0] off;
        entry_valid = '0;
        entry_wa    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off                = PTR_W'(i) - rd_ptr_q;
            entry_valid[i]     = ({1'b0, off} < count_q);
            entry_wa[4*i +: 4] = mem_q[i].wa;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between the writeback stage (always
// preferred) and an auxiliary requester whose writes are queued in a FIFO and drained
// on free cycles.
// Optional feature macro: RFARB_STARVE_GUARD_EN (starvation guard forcing a WB stall).
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   wb_we, wb_wa, wb_wd      : writeback write request (not back-pressurable)
//   aux_valid/aux_wa/aux_wd  : aux write request; aux_ready accepts it
//   rf_we, rf_wa, rf_wd      : registered register-file write port
//   busy_mask                : aux writes in flight per register R0-R14
//   fifo_count               : aux FIFO occupancy
//   err_r15                  : sticky flag, a write to R15 was dropped
//   wb_stall                 : pipeline hold-off from the starvation guard
module regfile_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wb_we,
    input  logic [3:0]              wb_wa,
    input  logic [31:0]             wb_wd,
    input  logic                    aux_valid,
    input  logic [3:0]              aux_wa,
    input  logic [31:0]             aux_wd,
    output logic                    aux_ready,
    output logic                    rf_we,
    output logic [3:0]              rf_wa,
    output logic [31:0]             rf_wd,
    output logic [14:0]             busy_mask,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    err_r15,
    output logic                    wb_stall
);

    rf_wr_t             fifo_head;
    logic [RF_WR_W-1:0] fifo_head_flat;
    logic               fifo_full, fifo_empty;
    logic               fifo_push, fifo_pop;
    logic [DEPTH-1:0]   entry_valid;
    logic [4*DEPTH-1:0] entry_wa;

    grant_e             grant;
    logic               wb_valid;
    logic               aux_accept;

    logic               rf_we_q,   rf_we_d;
    logic [3:0]         rf_wa_q,   rf_wa_d;
    logic [31:0]        rf_wd_q,   rf_wd_d;
    logic               out_aux_q, out_aux_d;
    logic               err_r15_q, err_r15_d;

    // Ready looks only at registered occupancy, so a same-edge pop never opens a slot early.
    assign aux_ready  = !fifo_full && !reset;
    assign aux_accept = aux_valid && aux_ready;
    assign fifo_push  = aux_accept && (aux_wa != R15_ADDR);
    assign wb_valid   = wb_we && (wb_wa != R15_ADDR);
    assign fifo_head  = rf_wr_t'(fifo_head_flat);

    rf_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (fifo_push),
        .push_data   ({aux_wa, aux_wd}),
        .pop         (fifo_pop),
        .head        (fifo_head_flat),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count),
        .entry_valid (entry_valid),
        .entry_wa    (entry_wa)
    );

`ifdef RFARB_STARVE_GUARD_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_q, starve_d;

    // Counts edges the head waited; hitting the limit hands it the port on the next edge.
    always_comb begin
        starve_d = starve_q;
        if (fifo_pop) begin
            starve_d = '0;
        end else if (!fifo_empty) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign wb_stall = (starve_q == STARVE_W'(STARVE_LIMIT));
`else
    assign wb_stall = 1'b0;
`endif

    always_comb begin
        if (wb_stall && !fifo_empty) begin
            grant = GNT_AUX;
        end else if (wb_valid) begin
            grant = GNT_WB;
        end else if (!fifo_empty) begin
            grant = GNT_AUX;
        end else begin
            grant = GNT_NONE;
        end
    end

    assign fifo_pop = (grant == GNT_AUX);

    always_comb begin
        rf_we_d   = 1'b0;
        rf_wa_d   = rf_wa_q;
        rf_wd_d   = rf_wd_q;
        out_aux_d = 1'b0;
        unique case (grant)
            GNT_WB: begin
                rf_we_d = 1'b1;
                rf_wa_d = wb_wa;
                rf_wd_d = wb_wd;
            end
            GNT_AUX: begin
                rf_we_d   = 1'b1;
                rf_wa_d   = fifo_head.wa;
                rf_wd_d   = fifo_head.wd;
                out_aux_d = 1'b1;
            end
            default: ;
        endcase
        err_r15_d = err_r15_q
                  || (wb_we && (wb_wa == R15_ADDR))
                  || (aux_accept && (aux_wa == R15_ADDR));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q   <= 1'b0;
            rf_wa_q   <= '0;
            rf_wd_q   <= '0;
            out_aux_q <= 1'b0;
            err_r15_q <= 1'b0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_wa_q   <= rf_wa_d;
            rf_wd_q   <= rf_wd_d;
            out_aux_q <= out_aux_d;
            err_r15_q <= err_r15_d;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) busy_mask = busy_mask | reg_onehot(entry_wa[4*i +: 4]);
        end
        if (rf_we_q && out_aux_q) busy_mask = busy_mask | reg_onehot(rf_wa_q);
    end

    assign rf_we   = rf_we_q;
    assign rf_wa   = rf_wa_q;
    assign rf_wd   = rf_wd_q;
    assign err_r15 = err_r15_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [3:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        aux_valid;
    logic [3:0]  aux_wa;
    logic [31:0] aux_wd;
    logic        aux_ready;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [14:0] busy_mask;
    logic [2:0]  fifo_count;
    logic        err_r15;
    logic        wb_stall;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

`ifdef RFARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .DEPTH        (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_we      (wb_we),
        .wb_wa      (wb_wa),
        .wb_wd      (wb_wd),
        .aux_valid  (aux_valid),
        .aux_wa     (aux_wa),
        .aux_wd     (aux_wd),
        .aux_ready  (aux_ready),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .busy_mask  (busy_mask),
        .fifo_count (fifo_count),
        .err_r15    (err_r15),
        .wb_stall   (wb_stall)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_we     = 1'b0;
        wb_wa     = '0;
        wb_wd     = '0;
        aux_valid = 1'b0;
        aux_wa    = '0;
        aux_wd    = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();

        // Reset state
        tick();
        tick();
        check_eq("rst_rf_we",   32'(rf_we),      32'd0);
        check_eq("rst_rf_wa",   32'(rf_wa),      32'd0);
        check_eq("rst_rf_wd",   rf_wd,           32'd0);
        check_eq("rst_count",   32'(fifo_count), 32'd0);
        check_eq("rst_busy",    32'(busy_mask),  32'd0);
        check_eq("rst_err",     32'(err_r15),    32'd0);
        check_eq("rst_stall",   32'(wb_stall),   32'd0);
        check_eq("rst_ready",   32'(aux_ready),  32'd0);
        reset = 1'b0;
        tick();
        check_eq("post_rst_ready", 32'(aux_ready), 32'd1);
        check_eq("post_rst_we",    32'(rf_we),     32'd0);

        // WB only
        wb_we = 1'b1; wb_wa = 4'd3; wb_wd = 32'hDEADBEEF;
        tick();
        wb_we = 1'b0;
        check_eq("wb_we",   32'(rf_we),     32'd1);
        check_eq("wb_wa",   32'(rf_wa),     32'd3);
        check_eq("wb_wd",   rf_wd,          32'hDEADBEEF);
        check_eq("wb_busy", 32'(busy_mask), 32'd0);
        tick();
        check_eq("wb_idle_we", 32'(rf_we), 32'd0);

        // Aux only: busy from n+1, write in n+2, clear in n+3
        aux_valid = 1'b1; aux_wa = 4'd5; aux_wd = 32'h11;
        tick();
        aux_valid = 1'b0;
        check_eq("aux_n1_busy",  32'(busy_mask),  32'h20);
        check_eq("aux_n1_count", 32'(fifo_count), 32'd1);
        check_eq("aux_n1_we",    32'(rf_we),      32'd0);
        tick();
        check_eq("aux_n2_we",    32'(rf_we),      32'd1);
        check_eq("aux_n2_wa",    32'(rf_wa),      32'd5);
        check_eq("aux_n2_wd",    rf_wd,           32'h11);
        check_eq("aux_n2_busy",  32'(busy_mask),  32'h20);
        check_eq("aux_n2_count", 32'(fifo_count), 32'd0);
        tick();
        check_eq("aux_n3_we",    32'(rf_we),      32'd0);
        check_eq("aux_n3_busy",  32'(busy_mask),  32'd0);

        // Collision: six WB writes to R1, aux pushes R2..R5 then holds R6 while full
        for (int k = 0; k < 6; k++) begin
            wb_we = 1'b1; wb_wa = 4'd1; wb_wd = 32'h100 + 32'(k);
            aux_valid = 1'b1;
            aux_wa = (k < 4) ? 4'(2 + k) : 4'd6;
            aux_wd = (k < 4) ? 32'h202 + 32'(k) : 32'h66;
            tick();
            check_eq("col_wb_wa",  32'(rf_wa), 32'd1);
            check_eq("col_wb_wd",  rf_wd,      32'h100 + 32'(k));
            check_eq("col_count",  32'(fifo_count), (k < 4) ? 32'(k + 1) : 32'd4);
        end
        check_eq("col_full_ready", 32'(aux_ready), 32'd0);
        check_eq("col_full_busy",  32'(busy_mask), 32'h3C);
        idle_inputs();
        for (int j = 0; j < 4; j++) begin
            tick();
            check_eq("col_drain_we", 32'(rf_we), 32'd1);
            check_eq("col_drain_wa", 32'(rf_wa), 32'(2 + j));
            check_eq("col_drain_wd", rf_wd,      32'h202 + 32'(j));
            if (j == 0) check_eq("col_drain_busy", 32'(busy_mask), 32'h3C);
        end
        tick();
        check_eq("col_end_we",    32'(rf_we),      32'd0);
        check_eq("col_end_count", 32'(fifo_count), 32'd0);
        check_eq("col_end_busy",  32'(busy_mask),  32'd0);

        // R15 via aux: accepted, dropped, sticky error
        aux_valid = 1'b1; aux_wa = 4'hF; aux_wd = 32'hF;
        check_eq("r15_aux_ready", 32'(aux_ready), 32'd1);
        tick();
        aux_valid = 1'b0;
        check_eq("r15_aux_count", 32'(fifo_count), 32'd0);
        check_eq("r15_aux_err",   32'(err_r15),    32'd1);
        check_eq("r15_aux_busy",  32'(busy_mask),  32'd0);
        tick();
        check_eq("r15_aux_we",    32'(rf_we),   32'd0);
        check_eq("r15_sticky",    32'(err_r15), 32'd1);
        do_reset();
        tick();
        check_eq("r15_rst_clear", 32'(err_r15), 32'd0);

        // R15 via WB
        wb_we = 1'b1; wb_wa = 4'hF; wb_wd = 32'h1234;
        tick();
        wb_we = 1'b0;
        check_eq("r15_wb_we",  32'(rf_we),   32'd0);
        check_eq("r15_wb_err", 32'(err_r15), 32'd1);

        // Reset mid-queue: three entries held back by WB, then discarded
        do_reset();
        for (int k = 0; k < 3; k++) begin
            wb_we = 1'b1; wb_wa = 4'd0; wb_wd = 32'(k);
            aux_valid = 1'b1; aux_wa = 4'(7 + k); aux_wd = 32'h700 + 32'(k);
            tick();
        end
        idle_inputs();
        check_eq("mq_count", 32'(fifo_count), 32'd3);
        check_eq("mq_busy",  32'(busy_mask),  32'h380);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mq_rst_count", 32'(fifo_count), 32'd0);
        check_eq("mq_rst_busy",  32'(busy_mask),  32'd0);
        check_eq("mq_rst_we",    32'(rf_we),      32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("mq_after_we", 32'(rf_we), 32'd0);
        end

        // Starvation: continuous WB with one aux entry queued
        do_reset();
        wb_we = 1'b1; wb_wa = 4'd1; wb_wd = 32'h55;
        aux_valid = 1'b1; aux_wa = 4'd4; aux_wd = 32'h44;
        tick();
        aux_valid = 1'b0;
        check_eq("sv_count", 32'(fifo_count), 32'd1);
        check_eq("sv_stall0", 32'(wb_stall), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            if (!wb_we) break;
            tick();
            check_eq("sv_wb_wa", 32'(rf_wa), 32'd1);
            check_eq("sv_stall", 32'(wb_stall), (GUARD && k == 8) ? 32'd1 : 32'd0);
            if (wb_stall) wb_we = 1'b0;
        end
        if (!GUARD) check_eq("sv_starved_count", 32'(fifo_count), 32'd1);
        wb_we = 1'b0;
        tick();
        check_eq("sv_aux_we",    32'(rf_we),      32'd1);
        check_eq("sv_aux_wa",    32'(rf_wa),      32'd4);
        check_eq("sv_aux_wd",    rf_wd,           32'h44);
        check_eq("sv_aux_stall", 32'(wb_stall),   32'd0);
        check_eq("sv_aux_count", 32'(fifo_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Pipeline contract: no WB request while the guard stalls.
    always @(negedge clk) begin
        if (!reset && wb_stall === 1'b1) check_eq("stall_wb_we", 32'(wb_we), 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
